// File: rtl/seq_engine.sv
// Register-file sequence engine: seeds r0/r1, then fills r[i] = r[i-2] OP r[i-1]
// up to N terms, with start/busy/done handshake, sticky overflow and registered read-back.
module seq_engine #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  seed0,
  input  logic [WIDTH-1:0]  seed1,
  input  logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0]   N_MIN   = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0]   N_MAX   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   N_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_TWO = ADDR_W'(2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED0 = 3'd1,
    S_SEED1 = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [1:0]          op_r;
  logic [WIDTH-1:0]    seed0_r, seed1_r;
  logic [ADDR_W:0]     n_r, n_clamp_s, n_m1_s;
  logic [ADDR_W-1:0]   idx_r, idx_m1_s, idx_m2_s;
  logic                busy_r, done_r, ovf_r;
  logic [WIDTH-1:0]    rd_data_r;
  logic [WIDTH-1:0]    opa_s, opb_s, alu_s;
  logic [WIDTH:0]      sum_s, dif_s;
  logic                carry_s;
  logic                wr_en_s, ovf_set_s, busy_nxt_s, done_nxt_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [WIDTH-1:0]    wr_data_s;
  logic                accept_s;

  assign accept_s = (state_r == S_IDLE) && start;
  assign n_m1_s   = n_r - N_ONE;
  assign idx_m1_s = idx_r - IDX_ONE;
  assign idx_m2_s = idx_r - IDX_TWO;
  assign opa_s    = mem_r[idx_m2_s];
  assign opb_s    = mem_r[idx_m1_s];

  // Term count clamp to [2, DEPTH]
  always_comb begin
    if (count < N_MIN) begin
      n_clamp_s = N_MIN;
    end else if (count > N_MAX) begin
      n_clamp_s = N_MAX;
    end else begin
      n_clamp_s = count;
    end
  end

  // ALU; carry_s is carry-out for add and borrow for sub
  always_comb begin
    sum_s = {1'b0, opa_s} + {1'b0, opb_s};
    dif_s = {1'b0, opa_s} - {1'b0, opb_s};
    case (op_r)
      2'b00: begin alu_s = sum_s[WIDTH-1:0]; carry_s = sum_s[WIDTH]; end
      2'b01: begin alu_s = dif_s[WIDTH-1:0]; carry_s = dif_s[WIDTH]; end
      2'b10: begin alu_s = opa_s ^ opb_s;    carry_s = 1'b0;         end
      2'b11: begin alu_s = opa_s | opb_s;    carry_s = 1'b0;         end
      default: begin alu_s = {WIDTH{1'b0}}; carry_s = 1'b0;          end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state
  always_comb begin
    case (state_r)
      S_IDLE:  state_s = start ? S_SEED0 : S_IDLE;
      S_SEED0: state_s = S_SEED1;
      S_SEED1: state_s = (n_r > N_MIN) ? S_RUN : S_DONE;
      S_RUN:   state_s = ({1'b0, idx_r} == n_m1_s) ? S_DONE : S_RUN;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM outputs: write port and next values of the registered flags
  always_comb begin
    wr_en_s    = 1'b0;
    wr_addr_s  = {ADDR_W{1'b0}};
    wr_data_s  = {WIDTH{1'b0}};
    ovf_set_s  = 1'b0;
    busy_nxt_s = (state_s == S_SEED0) || (state_s == S_SEED1) || (state_s == S_RUN);
    done_nxt_s = (state_s == S_DONE);
    case (state_r)
      S_SEED0: begin wr_en_s = 1'b1; wr_addr_s = {ADDR_W{1'b0}}; wr_data_s = seed0_r; end
      S_SEED1: begin wr_en_s = 1'b1; wr_addr_s = IDX_ONE;        wr_data_s = seed1_r; end
      S_RUN: begin
        wr_en_s   = 1'b1;
        wr_addr_s = idx_r;
        wr_data_s = alu_s;
        ovf_set_s = carry_s;
      end
      default: wr_en_s = 1'b0;
    endcase
  end

  // Register file and read-back; read sees the pre-write value on a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= {WIDTH{1'b0}};
      end
      rd_data_r <= {WIDTH{1'b0}};
    end else begin
      rd_data_r <= mem_r[rd_addr];
      if (wr_en_s) begin
        mem_r[wr_addr_s] <= wr_data_s;
      end
    end
  end

  // Run capture, write index, handshake flags and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 2'b00;
      seed0_r <= {WIDTH{1'b0}};
      seed1_r <= {WIDTH{1'b0}};
      n_r     <= {(ADDR_W+1){1'b0}};
      idx_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (accept_s) begin
        op_r    <= op;
        seed0_r <= seed0;
        seed1_r <= seed1;
        n_r     <= n_clamp_s;
        ovf_r   <= 1'b0;
      end else if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
      if (state_r == S_SEED1) begin
        idx_r <= IDX_TWO;
      end else if (state_r == S_RUN) begin
        idx_r <= idx_r + IDX_ONE;
      end
    end
  end

  assign rd_data = rd_data_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_seq_engine.sv
// Directed, table-driven bench for seq_engine at WIDTH=8, ADDR_W=5 (DEPTH=32).
module tb_seq_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] seed0, seed1;
  logic [5:0] count;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy, done, ovf;

  int checks = 0;
  int errors = 0;

  seq_engine #(.WIDTH(8), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .seed0(seed0), .seed1(seed1),
    .count(count), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [5:0] cnt;
    int         exp_busy;
    logic       exp_ovf;
    logic [4:0] addr;
    logic [7:0] val;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] fib[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle later.
  task automatic rd_chk(input logic [4:0] a, input logic [7:0] e, input string nm);
    rd_addr = a;
    @(negedge clk);
    chk(nm, {24'd0, rd_data}, {24'd0, e});
  endtask

  // Called at a negedge in IDLE; returns at the first negedge back in IDLE after done.
  task automatic do_run(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [5:0] c, output int nbusy, output int ndone);
    op = o; seed0 = a; seed1 = b; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    ndone = 0;
    for (int k = 0; k < 80; k++) begin
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) ndone++;
      if (ndone > 0 && busy !== 1'b1 && done !== 1'b1) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, nd, extra, got;

    vecs[0] = '{2'b00, 8'd0,   8'd1,   6'd10, 10, 1'b0, 5'd9,  8'd34};
    vecs[1] = '{2'b00, 8'd1,   8'd1,   6'd13, 13, 1'b0, 5'd12, 8'd233};
    vecs[2] = '{2'b00, 8'd1,   8'd1,   6'd14, 14, 1'b1, 5'd13, 8'd121};
    vecs[3] = '{2'b01, 8'd3,   8'd5,   6'd4,  4,  1'b1, 5'd3,  8'd7};
    vecs[4] = '{2'b01, 8'd5,   8'd3,   6'd7,  7,  1'b0, 5'd6,  8'd1};
    vecs[5] = '{2'b10, 8'hAA,  8'h55,  6'd0,  2,  1'b0, 5'd1,  8'h55};
    vecs[6] = '{2'b11, 8'd1,   8'd2,   6'd33, 32, 1'b0, 5'd31, 8'd3};
    fib = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; seed0 = 8'd0; seed1 = 8'd0;
    count = 6'd0; rd_addr = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    chk("reset_rd_data", {24'd0, rd_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk(5'd7, 8'd0, "reset_mem7");

    for (int i = 0; i < 7; i++) begin
      do_run(vecs[i].op, vecs[i].s0, vecs[i].s1, vecs[i].cnt, nb, nd);
      chk($sformatf("vec%0d_busy_cycles", i), nb, vecs[i].exp_busy);
      chk($sformatf("vec%0d_done_pulses", i), nd, 1);
      chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
      rd_chk(vecs[i].addr, vecs[i].val, $sformatf("vec%0d_last_term", i));
      if (i == 5) rd_chk(5'd2, 8'd2, "clamp_lo_r2_kept");
    end

    // count=DEPTH+1 run (or, seeds 1/2) must have written every entry
    rd_chk(5'd0, 8'd1, "full_r0");
    rd_chk(5'd1, 8'd2, "full_r1");
    for (int a = 2; a < 32; a++) rd_chk(a[4:0], 8'd3, $sformatf("full_r%0d", a));

    // start pulses while busy/done with different operands must be ignored
    op = 2'b00; seed0 = 8'd1; seed1 = 8'd1; count = 6'd5; start = 1'b1;
    @(negedge clk);
    nb = 0; nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy === 1'b1) nb++;
      if (done === 1'b1) nd++;
      op = 2'b10; seed0 = 8'd9; seed1 = 8'd9; count = 6'd20;
      start = busy | done;
      if (nd > 0 && busy !== 1'b1 && done !== 1'b1) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore_busy_cycles", nb, 5);
    chk("ignore_done_pulses", nd, 1);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) extra++;
    end
    chk("ignore_no_extra_run", extra, 0);
    rd_chk(5'd0, 8'd1, "ignore_r0");
    rd_chk(5'd1, 8'd1, "ignore_r1");
    rd_chk(5'd4, 8'd5, "ignore_r4");
    rd_chk(5'd5, 8'd3, "ignore_r5_kept");

    // sticky overflow, then cleared by the next accepted start
    do_run(2'b00, 8'd1, 8'd1, 6'd14, nb, nd);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    @(negedge clk);
    chk("ovf_sticky_idle", {31'd0, ovf}, 32'd1);
    op = 2'b10; seed0 = 8'hF0; seed1 = 8'h0F; count = 6'd20; rd_addr = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ovf_clear_on_start", {31'd0, ovf}, 32'd0);
    chk("xor_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    chk("xor_rd_r0_before_reset", {24'd0, rd_data}, 32'hF0);

    // reset in the middle of RUN
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    chk("midrst_rd_data", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) extra++;
    end
    chk("midrst_no_activity", extra, 0);
    for (int a = 0; a < 32; a++) rd_chk(a[4:0], 8'd0, $sformatf("midrst_r%0d", a));

    // fresh Fibonacci run with rd_addr held on 5: old value after E6, new value after E7
    op = 2'b00; seed0 = 8'd0; seed1 = 8'd1; count = 6'd10; rd_addr = 5'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rdw_old_value", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    chk("rdw_new_value", {24'd0, rd_data}, 32'd5);
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rdw_done_seen", got, 1);
    @(negedge clk);
    chk("rdw_ovf", {31'd0, ovf}, 32'd0);
    for (int a = 0; a < 10; a++) rd_chk(a[4:0], fib[a], $sformatf("fib_r%0d", a));
    rd_chk(5'd10, 8'd0, "fib_r10_untouched");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
